pipe_chain: RTL

Parametrised chain of DEPTH pipeline registers with per-stage hold and flush. It generalises the fixed IF_ID / ID_EX / EX_MEM / MEM_WB registers and the hazard unit's PC_Hold / IF_ID_Hold / ID_EX_Flush controls into one block. Payload width and stage count are parameters. Every stage carries a valid bit, so holds insert bubbles automatically. Hazard and forwarding logic can observe each stage's contents, and a saturating counter records killed entries.

---
 rtl/pipe_chain_pkg.sv | 35 +++
 rtl/pipe_chain_stage.sv | 39 +++
 rtl/pipe_chain.sv | 103 ++++++++++
 3 files changed

// File: rtl/pipe_chain_pkg.sv
// pipe_chain_pkg
// Shared helpers for the pipe_chain block:
//   popcount  - number of set bits, used for occupancy and flush accounting
//   sat_add   - add that clamps at the all-ones value of a w-bit counter
//   CNT_W_DEFAULT - default width of the flush counter
// Both helpers work on a fixed 64-bit carrier, so DEPTH and CNT_W must stay
// at or below 64.
package pipe_chain_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int MAX_BITS      = 64;

  function automatic int popcount(input logic [MAX_BITS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Clamp to 2^w-1 instead of wrapping; the extra sum bit catches overflow
  // of the 64-bit carrier itself.
  function automatic logic [MAX_BITS-1:0] sat_add(input logic [MAX_BITS-1:0] a,
                                                  input logic [MAX_BITS-1:0] b,
                                                  input int w);
    logic [MAX_BITS:0]   sum;
    logic [MAX_BITS-1:0] max_val;
    max_val = (w >= MAX_BITS) ? '1 : ((MAX_BITS'(1) << w) - MAX_BITS'(1));
    sum     = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[MAX_BITS-1:0];
  endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// pipe_chain_stage
// One pipeline register: a payload plus its valid bit.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   acc          : stage takes a new value this edge (bubble if send=0)
//   send         : the source presents a real item
//   flush        : kill the next-cycle content; wins over hold and accept
//   src_data     : payload from the upstream stage or the input port
//   valid, data  : registered contents
module pipe_chain_stage
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             acc,
  input  logic             send,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A flush only clears valid; the payload follows acc alone, so a held and
  // flushed stage keeps its old data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (acc) begin
        data  <= src_data;
        valid <= send;
      end
      if (flush) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain
// Chain of DEPTH pipeline registers with per-stage hold and flush, exposing
// every stage for hazard/forwarding logic and counting flushed items.
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   in_valid/in_data/in_ready   : upstream handshake into stage 0
//   hold[i]                 : freeze stage i
//   flush[i]                : kill stage i's next-cycle content
//   out_valid/out_data/out_ready: downstream handshake from the last stage
//   stage_valid, stage_data : per-stage contents, stage i at [i*WIDTH +: WIDTH]
//   occupancy               : number of valid stages
//   flush_count             : saturating count of valid items killed by flush
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           hold,
  input  logic [DEPTH-1:0]           flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           flush_count
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] send;
  logic [DEPTH-1:0] killed;

  // Accept ripples from the output back toward the input: a stage may load
  // when it is not held and is either empty or its successor loads too.
  // A held stage still passes nothing on, so its successor loads a bubble.
  always_comb begin
    acc  = '0;
    send = '0;
    acc[DEPTH-1] = ~hold[DEPTH-1] & (~valid[DEPTH-1] | out_ready);
    for (int i = DEPTH-2; i >= 0; i--) begin
      acc[i] = ~hold[i] & (~valid[i] | acc[i+1]);
    end
    send[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      send[i] = valid[i-1] & ~hold[i-1];
    end
  end

  // An item is lost to flush either as it arrives (stage loading a real
  // item) or as it sits (stage keeping a valid item).
  always_comb begin
    killed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      killed[i] = flush[i] & (acc[i] ? send[i] : valid[i]);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    if (i == 0) begin : g_src_in
      assign src_data = in_data;
    end else begin : g_src_prev
      assign src_data = stage_data[(i-1)*WIDTH +: WIDTH];
    end

    pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clock    (clock),
      .reset    (reset),
      .acc      (acc[i]),
      .send     (send[i]),
      .flush    (flush[i]),
      .src_data (src_data),
      .valid    (valid[i]),
      .data     (stage_data[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      flush_count <= '0;
    end else begin
      flush_count <= CNT_W'(sat_add(MAX_BITS'(flush_count),
                                    MAX_BITS'(popcount(MAX_BITS'(killed))),
                                    CNT_W));
    end
  end

  assign in_ready    = acc[0];
  assign out_valid   = valid[DEPTH-1] & ~hold[DEPTH-1];
  assign out_data    = stage_data[(DEPTH-1)*WIDTH +: WIDTH];
  assign stage_valid = valid;
  assign occupancy   = OCC_W'(popcount(MAX_BITS'(valid)));

endmodule
